// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: filtered PS/2 device-to-host receiver that folds E0/F0/E1 prefixes into toggle-strobe key events.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic [7:0]  err_count
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t        state;
    logic          clk_s1, clk_s2, dat_s1, dat_s2, filt_clk, filt_prev;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    bit_cnt, skip;
    logic [7:0]    shift, byte_q;
    logic          par, byte_valid, ext, rel, fall, is_drop;
    assign fall    = filt_prev & ~filt_clk;
    assign is_drop = byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {clk_s1, clk_s2, dat_s1, dat_s2, filt_clk, filt_prev} <= '1;
            flt_cnt <= '0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk)
                flt_cnt <= '0;
            else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                flt_cnt  <= '0;
            end else
                flt_cnt <= flt_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            skip       <= '0;
            shift      <= '0;
            byte_q     <= '0;
            par        <= 1'b0;
            byte_valid <= 1'b0;
            ext        <= 1'b0;
            rel        <= 1'b0;
            frame_err  <= 1'b0;
            ps2_key    <= '0;
        end else begin
            frame_err  <= 1'b0;
            byte_valid <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        bit_cnt   <= '0;
                        state     <= dat_s2 ? IDLE : DATA;
                        frame_err <= dat_s2;
                    end
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dat_s2 && ^{shift, par}) begin
                            byte_valid <= 1'b1;
                            byte_q     <= shift;
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            rel       <= 1'b0;
                        end
                    end
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    to_cnt    <= '0;
                end else
                    to_cnt <= to_cnt + 1'b1;
            end
            // Pause (E1) swallows the following 7 bytes of its fixed sequence
            if (byte_valid) begin
                if (skip != 3'd0)
                    skip <= skip - 1'b1;
                else if (byte_q == 8'hE0)
                    ext <= 1'b1;
                else if (byte_q == 8'hF0)
                    rel <= 1'b1;
                else if (byte_q == 8'hE1) begin
                    skip <= 3'd7;
                    ext  <= 1'b0;
                    rel  <= 1'b0;
                end else if (is_drop) begin
                    ext <= 1'b0;
                    rel <= 1'b0;
                end else begin
                    ps2_key <= {~ps2_key[10], ~rel, ext, byte_q};
                    ext     <= 1'b0;
                    rel     <= 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_count <= '0;
        else if (frame_err && err_count != 8'hFF)
            err_count <= err_count + 1'b1;
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: scoreboard bench driving PS/2 frames and comparing decoded key events.
module tb_ps2_scancode_rx;
    localparam int TMO = 2000;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic [7:0]  err_count;
    int          checks = 0, failures = 0, err_seen = 0;
    logic        exp_strobe = 1'b0, prev_strobe = 1'b0;
    logic [10:0] exp_q[$];

    ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_key(ps2_key), .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n)
            prev_strobe = 1'b0;
        else begin
            if (frame_err) err_seen++;
            if (ps2_key[10] != prev_strobe) begin
                prev_strobe = ps2_key[10];
                if (exp_q.size() == 0)
                    check("spurious_event", {21'd0, ps2_key}, 32'h7FF);
                else
                    check("key", {21'd0, ps2_key}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic expect_key(input logic pressed, input logic ext, input logic [7:0] code);
        exp_strobe = ~exp_strobe;
        exp_q.push_back({exp_strobe, pressed, ext, code});
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (10) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11);
        repeat (20) @(posedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_key", {21'd0, ps2_key}, 0);
        check("rst_err", {31'd0, frame_err}, 0);
        check("rst_cnt", {24'd0, err_count}, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        expect_key(1, 0, 8'h1C); send_frame(8'h1C, 0);
        expect_key(0, 0, 8'h1C); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        drain("drain_make_break");
        check("no_err_basic", err_seen, 0);

        send_frame(8'hE0, 0);
        expect_key(1, 1, 8'h74); send_frame(8'h74, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0);
        expect_key(0, 1, 8'h74); send_frame(8'h74, 0);
        drain("drain_ext");

        send_frame(8'h1C, 1);
        check("parity_err_pulse", err_seen, 1);
        check("parity_err_cnt", {24'd0, err_count}, 1);
        expect_key(1, 0, 8'h1C); send_frame(8'h1C, 0);
        drain("drain_after_parity");

        send_bits(11'h0A6, 5);
        repeat (TMO + 10) @(posedge clk);
        check("timeout_pulse", err_seen, 2);
        check("timeout_cnt", {24'd0, err_count}, 2);
        expect_key(1, 0, 8'h29); send_frame(8'h29, 0);
        drain("drain_after_timeout");

        send_frame(8'hE1, 0); send_frame(8'h14, 0); send_frame(8'h77, 0); send_frame(8'hE1, 0);
        send_frame(8'hF0, 0); send_frame(8'h14, 0); send_frame(8'hF0, 0); send_frame(8'h77, 0);
        expect_key(1, 0, 8'h15); send_frame(8'h15, 0);
        drain("drain_pause");
        check("pause_no_err", err_seen, 2);

        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(posedge clk);
        check("glitch_no_err", err_seen, 2);

        send_bits(11'h0B4, 5);
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_key", {21'd0, ps2_key}, 0);
        check("midrst_err", {31'd0, frame_err}, 0);
        check("midrst_cnt", {24'd0, err_count}, 0);
        exp_strobe = 1'b0;
        exp_q.delete();
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        expect_key(1, 0, 8'h5A); send_frame(8'h5A, 0);
        drain("drain_after_reset");
        check("post_rst_no_err", err_seen, 2);
        check("post_rst_cnt", {24'd0, err_count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
